// File: rtl/perf_counter_csr_reader.sv
// Performance counter bank (cycle + NUM_EV events) with a 32-bit req/ack CSR read port.
// A lo-half read snapshots the hi half into a per-counter shadow so lo-then-hi pairs are atomic.
module perf_counter_csr_reader #(
  parameter int NUM_EV = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_EV-1:0] ev_in,
  input  logic [NUM_EV:0]   inhibit,
  input  logic              clr_all,
  input  logic              rd_req,
  input  logic [11:0]       rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              rd_err,
  input  logic              rd_ack
);

  localparam int NUM_CNT = NUM_EV + 1;
  localparam int HI_W    = CNT_W - 32;
  localparam int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t                         state;
  logic [NUM_CNT-1:0][CNT_W-1:0]  cnt_q;
  logic [NUM_CNT-1:0][31:0]       shadow_q;
  logic [NUM_CNT-1:0]             inc;

  logic [6:0]       reg_n;
  logic             hit;
  logic             hi_sel;
  logic [IDX_W-1:0] idx;
  logic [31:0]      hi_ext;
  logic             accept;

  // Counter 0 is the cycle counter; counter i+1 follows ev_in[i].
  assign inc    = {ev_in & ~inhibit[NUM_EV:1], ~inhibit[0]};
  assign accept = rd_req & rd_ready;
  assign reg_n  = rd_addr[6:0];
  assign hi_sel = rd_addr[7];

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    if (rd_addr[11:8] == 4'hB) begin
      if (reg_n == 7'd0) begin
        hit = 1'b1;
      end else if (reg_n >= 7'd3 && reg_n <= 7'(NUM_EV + 2)) begin
        hit = 1'b1;
        idx = IDX_W'(reg_n - 7'd2);
      end
    end
  end

  always_comb begin
    hi_ext = '0;
    hi_ext[HI_W-1:0] = cnt_q[idx][CNT_W-1:32];
  end

  // NOTE: the shadow array is small register state, so it is reset like any other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (clr_all)     cnt_q[i] <= '0;
        else if (inc[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      if (clr_all)
        shadow_q <= '0;
      else if (accept && hit && !hi_sel)
        shadow_q[idx] <= hi_ext;
    end
  end

  // NOTE: non-blocking assignments keep every read of cnt_q/shadow_q on the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rd_ready <= 1'b1;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            state    <= RESP;
            rd_ready <= 1'b0;
            rd_valid <= 1'b1;
            rd_err   <= ~hit;
            if (!hit)        rd_data <= '0;
            else if (hi_sel) rd_data <= shadow_q[idx];
            else             rd_data <= cnt_q[idx][31:0];
          end
        end
        RESP: begin
          // Response is held untouched until the consumer acks; new requests are dropped.
          if (rd_ack) begin
            state    <= IDLE;
            rd_ready <= 1'b1;
            rd_valid <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          rd_ready <= 1'b1;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
